// File: rtl/bg_pkg.sv
// Shared sizes, types and frame-lock state for the background index fetch path.
package bg_pkg;

  localparam int SRC_W    = 320;
  localparam int SRC_H    = 240;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int ADDR_W   = 17;
  localparam int IDX_W    = 5;

  typedef logic [IDX_W-1:0]  pix_idx_t;
  typedef logic [ADDR_W-1:0] bg_addr_t;

  // Row base is only trustworthy once a frame origin has been seen.
  typedef enum logic {
    FRAME_WAIT,
    FRAME_LOCKED
  } frame_state_t;

endpackage

// File: rtl/bg_index_fetch_if.sv
// Video-in, ROM and palette-index signals of the background fetch stage.
interface bg_index_fetch_if;
  import bg_pkg::*;

  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       blank_in;
  logic       hs_in;
  logic       vs_in;
  bg_addr_t   rom_addr;
  pix_idx_t   rom_q;
  pix_idx_t   index_out;
  logic       index_valid;
  logic       hs_out;
  logic       vs_out;
  logic       blank_out;

  modport slave (
    input  DrawX, DrawY, blank_in, hs_in, vs_in, rom_q,
    output rom_addr, index_out, index_valid, hs_out, vs_out, blank_out
  );

  modport master (
    output DrawX, DrawY, blank_in, hs_in, vs_in, rom_q,
    input  rom_addr, index_out, index_valid, hs_out, vs_out, blank_out
  );

endinterface

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register with a per-bit reset value, used for syncs and pixel flags.
module sync_delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/bg_index_fetch.sv
// Maps 640x480 VGA coordinates onto a 2x-scaled 320x240 index ROM and keeps
// hs/vs/blank aligned with the returned palette index.
module bg_index_fetch #(
  parameter int               SRC_W     = bg_pkg::SRC_W,
  parameter int               SRC_H     = bg_pkg::SRC_H,
  parameter int               ROM_LAT   = 1,
  parameter bg_pkg::pix_idx_t OOR_INDEX = 5'd8
) (
  input  logic            Clk,
  input  logic            Reset,
  bg_index_fetch_if.slave bus
);
  import bg_pkg::*;

  localparam int         L        = 1 + ROM_LAT;
  localparam logic [9:0] X_LIM    = 10'(2 * SRC_W);
  localparam logic [9:0] Y_LIM    = 10'(2 * SRC_H);
  localparam bg_addr_t   ROW_STEP = bg_addr_t'(SRC_W);

  frame_state_t state_q, state_d;
  bg_addr_t     row_base, base_eff, addr_q;
  logic         x_zero_q;
  logic         origin, advance, in_range, frame_ok, active;
  logic [4:0]   pipe_d, pipe_q;

  // Row base steps one source row on every second display line, triggered only
  // by DrawX arriving at 0 so a held column 0 cannot advance it twice.
  always_comb begin
    origin   = (bus.DrawX == '0) && (bus.DrawY == '0);
    advance  = (bus.DrawX == '0) && !x_zero_q && !bus.DrawY[0] &&
               (bus.DrawY != '0) && (bus.DrawY < Y_LIM);
    in_range = (bus.DrawX < X_LIM) && (bus.DrawY < Y_LIM);
    base_eff = row_base;
    if (origin)       base_eff = '0;
    else if (advance) base_eff = row_base + ROW_STEP;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= FRAME_WAIT;
    else       state_q <= state_d;
  end

  // The origin pixel itself already counts as locked.
  always_comb begin
    state_d  = state_q;
    frame_ok = (state_q == FRAME_LOCKED);
    if (origin) begin
      state_d  = FRAME_LOCKED;
      frame_ok = 1'b1;
    end
  end

  assign active = bus.blank_in && frame_ok;

  // Out-of-range pixels leave the ROM address untouched.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      row_base <= '0;
      addr_q   <= '0;
      x_zero_q <= 1'b0;
    end else begin
      row_base <= base_eff;
      x_zero_q <= (bus.DrawX == '0);
      if (in_range) addr_q <= base_eff + {8'b0, bus.DrawX[9:1]};
    end
  end

  assign pipe_d = {bus.hs_in, bus.vs_in, bus.blank_in, in_range, active};

  sync_delay_line #(
    .WIDTH   (5),
    .DEPTH   (L),
    .RST_VAL (5'b11000)
  ) u_delay (
    .clk (Clk),
    .rst (Reset),
    .d   (pipe_d),
    .q   (pipe_q)
  );

  assign bus.rom_addr    = addr_q;
  assign bus.hs_out      = pipe_q[4];
  assign bus.vs_out      = pipe_q[3];
  assign bus.blank_out   = pipe_q[2];
  assign bus.index_valid = pipe_q[1] && pipe_q[0];
  assign bus.index_out   = bus.index_valid ? bus.rom_q : OOR_INDEX;

endmodule

// File: doc/bg_index_fetch.md
Name: bg_index_fetch

Overview:
- Upstream feeder for the background palette lookup. Converts the VGA controller's pixel coordinates into addresses for a 320x240 indexed-colour background ROM, scaled 2x to 640x480.
- Returns the 5-bit palette index for each pixel.
- Delays hs/vs/blank so that sync timing stays aligned with the index through the ROM latency.
- The palette lookup stage consumes the output index directly.

Parameters:
- SRC_W, 320, background ROM width in source pixels.
- SRC_H, 240, background ROM height in source pixels.
- ROM_LAT, 1, synchronous ROM read latency in clocks (1 or 2).
- OOR_INDEX, 5'd8, index driven for coordinates outside 640x480 or while blanked.

Ports:
- Clk, in, 1, pixel clock.
- Reset, in, 1, asynchronous active-high reset.
- DrawX, in, 10, current pixel column from the VGA controller.
- DrawY, in, 10, current pixel row from the VGA controller.
- blank_in, in, 1, high = active display region.
- hs_in, in, 1, horizontal sync from the VGA controller.
- vs_in, in, 1, vertical sync from the VGA controller.
- rom_addr, out, 17, registered address to the background ROM.
- rom_q, in, 5, ROM data, valid ROM_LAT clocks after rom_addr.
- index_out, out, 5, palette index to the palette lookup stage.
- index_valid, out, 1, index_out belongs to an active, in-range pixel.
- hs_out, out, 1, hs_in delayed by the pipeline latency L.
- vs_out, out, 1, vs_in delayed by the pipeline latency L.
- blank_out, out, 1, blank_in delayed by the pipeline latency L.

Behaviour:
- One clock domain: Clk. Reset is asynchronous and active-high.
- Reset values:
  - rom_addr = 0, index_out = OOR_INDEX, index_valid = 0.
  - hs_out = 1 and vs_out = 1 (syncs idle high); blank_out = 0.
  - All internal pipeline and address state cleared.
- Pipeline latency L = 1 + ROM_LAT.
  - Stage 0 registers rom_addr, plus an in-range flag and active flag per pixel.
  - Stages 1..ROM_LAT carry those flags and the syncs; rom_q is sampled in the last stage.
  - Every output corresponds to the DrawX/DrawY presented L clocks earlier.
- Address generation: no multiplier; incremental row base.
  - row_base (17 bit): set to 0 when DrawY == 0 and DrawX == 0.
  - On each cycle with DrawX == 0, DrawY odd-to-even transition (DrawY[0] == 0) and DrawY != 0: row_base += SRC_W.
  - rom_addr = row_base + DrawX[9:1], registered.
- Required identity: rom_addr == (DrawY>>1)*SRC_W + (DrawX>>1) for every in-range pixel of a full raster scan starting at (0,0).
- In-range means DrawX < 2*SRC_W and DrawY < 2*SRC_H.
  - Out of range: rom_addr holds its previous value (no ROM toggling), and the pixel is flagged out-of-range.
- Output selection at stage L:
  - If the pixel was in range and blank_in was high, index_out = rom_q and index_valid = 1.
  - Otherwise index_out = OOR_INDEX and index_valid = 0.
- Sync alignment: hs_out, vs_out and blank_out are shift-register delays of exactly L; they are never modified.
- Repeated coordinates: no state advances on DrawX == 0 other than row_base. A held DrawX == 0 across several clocks advances row_base once per line; the edge is detected on DrawX transitioning to 0.
- Mid-frame start after reset: row_base is invalid until the first (0,0). Until then, force index_valid = 0 while still passing the syncs through.
- Reset mid-line: the pipeline flushes immediately; outputs return to reset values asynchronously.
- Wrap-around: rom_addr never exceeds SRC_W*SRC_H-1 = 76799.

Decomposition:
- Shared package (bg_pkg) holds:
  - SRC_W, SRC_H and SCREEN_W/H = 640/480.
  - ADDR_W = 17 and IDX_W = 5.
  - Typedefs pix_idx_t (5 bit) and bg_addr_t (17 bit).
- One natural sub-module, sync_delay_line: a parameterised N-stage shift register used for hs/vs/blank and the per-pixel flags.

Test Plan:
- Reset asserted mid-scan -> next edge: index_valid = 0, hs_out = vs_out = 1, rom_addr = 0; clean restart at the next (0,0).
- Full-frame raster with a ROM model returning addr[4:0]:
  - (2,2) -> rom_addr 321; (639,479) -> 76799.
  - index_out for (4,0) appears exactly 2 clocks later (ROM_LAT = 1) with value 2.
- ROM_LAT = 2 build: hs_in pulse at DrawX = 656 -> hs_out pulse 3 clocks later, width unchanged. index stays aligned with blank_out.
- Blanked / out-of-range pixels:
  - DrawX = 700 -> index_out = 8, index_valid = 0, rom_addr unchanged.
  - Active pixel with blank_in = 0 -> same response.
- Start mid-frame (first coordinate (100,37)) -> index_valid stays 0 until after (0,0); the first valid pixel gives rom_addr 0.
- DrawX held at 0 for 3 clocks on line 2 -> row_base advances by 320 exactly once; (0,2) -> rom_addr 320.
